// File: rtl/trojan_adder_pkg.sv
// Shared defaults for the trojan_adder security-lab DUT and its trigger block.
// Counter width is derived from the occurrence threshold so it can hold TRIG_COUNT itself.
package trojan_adder_pkg;

  localparam int                  DEF_WIDTH        = 4;
  localparam int                  DEF_TRIG_A       = 8;
  localparam int                  DEF_TRIG_B       = 1;
  localparam int                  DEF_TRIG_COUNT   = 1;
  localparam logic [DEF_WIDTH:0]  DEF_PAYLOAD_MASK = 5'b00001;
  localparam bit                  DEF_STICKY       = 1'b0;

  function automatic int cnt_width(input int trig_count);
    return $clog2(trig_count + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_TRIG_COUNT);

endpackage

// File: rtl/trojan_adder_trigger.sv
// Trigger side of the Trojan: operand comparator, saturating occurrence counter
// and the optional sticky latch. fire_now is combinational for the current input.
module trojan_trigger
  import trojan_adder_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TRIG_A     = WIDTH'(DEF_TRIG_A),
  parameter logic [WIDTH-1:0] TRIG_B     = WIDTH'(DEF_TRIG_B),
  parameter int               TRIG_COUNT = DEF_TRIG_COUNT,
  parameter bit               STICKY     = DEF_STICKY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             fire_now,
  output logic             sticky_active
);

  localparam int             CNT_W = cnt_width(TRIG_COUNT);
  localparam logic [CNT_W:0] TC    = (CNT_W+1)'(TRIG_COUNT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic             match;
  logic [CNT_W:0]   cnt_inc;

  always_comb begin
    match    = in_valid && (A == TRIG_A) && (B == TRIG_B);
    cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
    fire_now = match && (cnt_inc >= TC);

    cnt_d = cnt_q;
    // Saturate at the threshold so every later match keeps firing.
    if (match && ({1'b0, cnt_q} < TC)) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end

    sticky_d = sticky_q || (STICKY && fire_now);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign sticky_active = sticky_q;

endmodule

// File: rtl/trojan_adder.sv
// Registered unsigned adder with carry-out; the trigger block decides when the
// sum is XOR-corrupted, and trojan_fired flags the corrupted result.
module trojan_adder
  import trojan_adder_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TRIG_A       = WIDTH'(DEF_TRIG_A),
  parameter logic [WIDTH-1:0] TRIG_B       = WIDTH'(DEF_TRIG_B),
  parameter int               TRIG_COUNT   = DEF_TRIG_COUNT,
  parameter logic [WIDTH:0]   PAYLOAD_MASK = (WIDTH+1)'(DEF_PAYLOAD_MASK),
  parameter bit               STICKY       = DEF_STICKY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   SUM,
  output logic             out_valid,
  output logic             trojan_fired
);

  logic           fire_now;
  logic           sticky_active;
  logic           corrupt;
  logic [WIDTH:0] true_sum;

  logic [WIDTH:0] sum_q, sum_d;
  logic           valid_q, valid_d;
  logic           fired_q, fired_d;

  trojan_trigger #(
    .WIDTH      (WIDTH),
    .TRIG_A     (TRIG_A),
    .TRIG_B     (TRIG_B),
    .TRIG_COUNT (TRIG_COUNT),
    .STICKY     (STICKY)
  ) u_trigger (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .A             (A),
    .B             (B),
    .fire_now      (fire_now),
    .sticky_active (sticky_active)
  );

  always_comb begin
    true_sum = {1'b0, A} + {1'b0, B};
    corrupt  = fire_now || (STICKY && sticky_active);

    sum_d   = sum_q;
    fired_d = fired_q;
    valid_d = 1'b0;
    if (in_valid) begin
      sum_d   = corrupt ? (true_sum ^ PAYLOAD_MASK) : true_sum;
      fired_d = corrupt;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
      fired_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      valid_q <= valid_d;
      fired_q <= fired_d;
    end
  end

  assign SUM          = sum_q;
  assign out_valid    = valid_q;
  assign trojan_fired = fired_q;

endmodule

// File: tb/tb_trojan_adder.sv
// Scoreboard bench for trojan_adder: three configurations (default, TRIG_COUNT=3,
// STICKY=1) driven from directed and random stimulus against a behavioural model.
module tb_trojan_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i [3];
  logic       v_i   [3];
  logic [3:0] a_i   [3];
  logic [3:0] b_i   [3];
  logic [4:0] sum_o [3];
  logic       ov_o  [3];
  logic       tf_o  [3];

  trojan_adder u_dut0 (
    .clk(clk), .rst(rst_i[0]), .in_valid(v_i[0]), .A(a_i[0]), .B(b_i[0]),
    .SUM(sum_o[0]), .out_valid(ov_o[0]), .trojan_fired(tf_o[0])
  );

  trojan_adder #(.TRIG_COUNT(3)) u_dut1 (
    .clk(clk), .rst(rst_i[1]), .in_valid(v_i[1]), .A(a_i[1]), .B(b_i[1]),
    .SUM(sum_o[1]), .out_valid(ov_o[1]), .trojan_fired(tf_o[1])
  );

  trojan_adder #(.STICKY(1'b1)) u_dut2 (
    .clk(clk), .rst(rst_i[2]), .in_valid(v_i[2]), .A(a_i[2]), .B(b_i[2]),
    .SUM(sum_o[2]), .out_valid(ov_o[2]), .trojan_fired(tf_o[2])
  );

  typedef struct {
    bit v;
    int sum;
    bit fired;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: trigger occurrences seen, sticky flag, held outputs.
  int occ    [3];
  bit lat    [3];
  int hsum   [3];
  bit hfired [3];
  int tc     [3] = '{1, 3, 1};
  bit st     [3] = '{1'b0, 1'b0, 1'b1};

  function automatic exp_t model(int k, bit r, bit v, int a, int b);
    exp_t e;
    bit   fire;
    bit   corrupt;
    int   ts;
    if (r) begin
      occ[k] = 0; lat[k] = 0; hsum[k] = 0; hfired[k] = 0;
      e = '{v: 1'b0, sum: 0, fired: 1'b0};
    end else if (v) begin
      ts   = a + b;
      fire = 1'b0;
      if (a == 8 && b == 1) begin
        if (occ[k] < tc[k]) occ[k] = occ[k] + 1;
        fire = (occ[k] >= tc[k]);
      end
      corrupt = fire || (st[k] && lat[k]);
      if (fire && st[k]) lat[k] = 1'b1;
      hsum[k]   = corrupt ? (ts ^ 1) : ts;
      hfired[k] = corrupt;
      e = '{v: 1'b1, sum: hsum[k], fired: hfired[k]};
    end else begin
      e = '{v: 1'b0, sum: hsum[k], fired: hfired[k]};
    end
    return e;
  endfunction

  function automatic void push_q(int k, exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int size_q(int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t pop_q(int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic chk(string name, int k, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s dut%0d got %0d want %0d at %0t", name, k, got, want, $time);
    end
  endtask

  // Monitor: each cycle's registered outputs against the expectation queued for that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
        if (size_q(k) > 0) begin
          e = pop_q(k);
          chk("out_valid", k, int'(ov_o[k]), int'(e.v));
          chk("sum", k, int'(sum_o[k]), e.sum);
          chk("trojan_fired", k, int'(tf_o[k]), int'(e.fired));
        end
      end
    end
  end

  // Called at a falling edge with inputs already set; they take effect at the next rising edge.
  task automatic tick();
    for (int k = 0; k < 3; k++) begin
      push_q(k, model(k, rst_i[k], v_i[k], int'(a_i[k]), int'(b_i[k])));
    end
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      rst_i[k] = 1'b0; v_i[k] = 1'b0; a_i[k] = 4'd0; b_i[k] = 4'd0;
    end
  endtask

  task automatic one(int k, bit r, bit v, int a, int b);
    idle_all();
    rst_i[k] = r; v_i[k] = v; a_i[k] = 4'(a); b_i[k] = 4'(b);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    for (int k = 0; k < 3; k++) rst_i[k] = 1'b1;
    @(negedge clk);
    repeat (2) tick();

    // Default configuration: plain sums, carry, single-shot trigger, hold, reset priority.
    one(0, 0, 1, 3, 2);
    one(0, 0, 1, 5, 7);
    repeat (3) one(0, 0, 0, 0, 0);
    one(0, 0, 1, 15, 15);
    one(0, 0, 1, 8, 1);
    one(0, 0, 1, 8, 2);
    one(0, 0, 1, 8, 1);
    one(0, 1, 1, 3, 2);
    one(0, 0, 0, 0, 0);

    // TRIG_COUNT=3: non-consecutive matches accumulate, saturation, reset re-arms.
    one(1, 0, 1, 8, 1);
    one(1, 0, 1, 4, 4);
    one(1, 0, 1, 8, 1);
    one(1, 0, 0, 8, 1);
    one(1, 0, 1, 8, 1);
    one(1, 0, 1, 8, 1);
    one(1, 1, 0, 0, 0);
    one(1, 0, 1, 8, 1);
    one(1, 0, 1, 8, 1);

    // STICKY=1: corruption persists until reset.
    one(2, 0, 1, 3, 2);
    one(2, 0, 1, 8, 1);
    one(2, 0, 1, 3, 2);
    one(2, 0, 0, 0, 0);
    one(2, 0, 1, 15, 15);
    one(2, 1, 0, 0, 0);
    one(2, 0, 1, 3, 2);

    repeat (400) begin
      for (int k = 0; k < 3; k++) begin
        rst_i[k] = ($urandom_range(0, 39) == 0);
        v_i[k]   = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) begin
          a_i[k] = 4'd8; b_i[k] = 4'd1;
        end else begin
          a_i[k] = 4'($urandom_range(0, 15));
          b_i[k] = 4'($urandom_range(0, 15));
        end
      end
      tick();
    end

    idle_all();
    repeat (3) tick();
    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
